// File: rtl/binary_to_hex_to_seven_seg.sv
// Signed 32-bit register value to sign digit plus 8 decimal digit codes.
// Sequential double-dabble, re-run continuously; outputs refresh once per 34-cycle pass.
module binary_to_hex_to_seven_seg #(
  parameter int unsigned NUM_BITS   = 32,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_BITS-1:0] registerToOutput,
  output logic [3:0]          hex8,
  output logic [3:0]          hex7,
  output logic [3:0]          hex6,
  output logic [3:0]          hex5,
  output logic [3:0]          hex4,
  output logic [3:0]          hex3,
  output logic [3:0]          hex2,
  output logic [3:0]          hex1,
  output logic [3:0]          hex0
);

  localparam int unsigned BCD_W = (NUM_DIGITS + 2) * 4;
  localparam int unsigned DIG_W = NUM_DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {CAPTURE, CONVERT, UPDATE} state_t;

  state_t              state, state_n;
  logic                sign;
  logic [NUM_BITS-1:0] mag;
  logic [BCD_W-1:0]    bcd, adj;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          hex8_r;
  logic [DIG_W-1:0]    disp;
  logic                ovf;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Anything in the two top BCD nibbles means the value needs more than 8 digits.
  assign ovf = (bcd[BCD_W-1:DIG_W] != '0);

  always_comb begin
    state_n = state;
    case (state)
      CAPTURE: state_n = CONVERT;
      CONVERT: if (cnt == CNT_W'(NUM_BITS - 1)) state_n = UPDATE;
      UPDATE:  state_n = CAPTURE;
      default: state_n = CAPTURE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= CAPTURE;
      sign   <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      hex8_r <= 4'hF;
      disp   <= '0;
    end else begin
      state <= state_n;
      case (state)
        CAPTURE: begin
          sign <= registerToOutput[NUM_BITS-1];
          mag  <= registerToOutput[NUM_BITS-1] ? (~registerToOutput + NUM_BITS'(1))
                                               : registerToOutput;
          bcd  <= '0;
          cnt  <= '0;
        end
        CONVERT: begin
          {bcd, mag} <= {adj[BCD_W-2:0], mag, 1'b0};
          cnt        <= cnt + CNT_W'(1);
        end
        UPDATE: begin
          if (ovf) begin
            hex8_r <= 4'hE;
            disp   <= '1;
          end else begin
            hex8_r <= sign ? 4'hA : 4'hF;
            disp   <= bcd[DIG_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hex8 = hex8_r;
  assign hex7 = disp[31:28];
  assign hex6 = disp[27:24];
  assign hex5 = disp[23:20];
  assign hex4 = disp[19:16];
  assign hex3 = disp[15:12];
  assign hex2 = disp[11:8];
  assign hex1 = disp[7:4];
  assign hex0 = disp[3:0];

endmodule

// File: tb/tb_binary_to_hex_to_seven_seg.sv
// Scoreboard bench: stimulus pushes expected displays, monitor checks at each refresh and holds between.
module tb_binary_to_hex_to_seven_seg;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] registerToOutput = 32'h12345678;
  logic [3:0]  hex8, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;

  int checks = 0;
  int errors = 0;
  int ecount = 0;              // rising edges since the last edge with RST high
  logic [35:0] q[$];

  localparam logic [35:0] RESET_VAL = {4'hF, 32'h0};

  binary_to_hex_to_seven_seg #(.NUM_BITS(32), .NUM_DIGITS(8)) dut (
    .CLK(CLK), .RST(RST), .registerToOutput(registerToOutput),
    .hex8(hex8), .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  function automatic logic [35:0] ref_model(input logic [31:0] v);
    longint u;
    longint m;
    logic [35:0] r;
    u = v;
    m = v[31] ? (64'sh1_0000_0000 - u) : u;
    if (m >= 100000000) begin
      r = {4'hE, 32'hFFFF_FFFF};
    end else begin
      r[35:32] = v[31] ? 4'hA : 4'hF;
      for (int k = 0; k < 8; k++) begin
        r[4*k +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t got %09h exp %09h", name, $time, got, exp);
    end
  endtask

  // Monitor: refresh every 34 non-reset edges, hold otherwise.
  initial begin : monitor
    logic [35:0] held;
    logic [35:0] got;
    logic [35:0] exp;
    held = RESET_VAL;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      got = {hex8, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
      if (ecount == 0) begin
        held = RESET_VAL;
        check("reset", got, held);
      end else if (ecount % 34 == 0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow at t=%0t got %09h exp <none>", $time, got);
        end else begin
          exp = q.pop_front();
          check("update", got, exp);
          held = exp;
        end
      end else begin
        check("hold", got, held);
      end
    end
  end

  task automatic do_reset(input int cycles, input logic [31:0] v);
    @(negedge CLK); #2;
    RST = 1'b1;
    q.delete();
    repeat (cycles) @(posedge CLK);
    @(negedge CLK); #2;
    RST = 1'b0;
    registerToOutput = v;
    q.push_back(ref_model(v));
  endtask

  // Present v for the next CAPTURE edge; optionally disturb the input mid-conversion.
  task automatic apply(input logic [31:0] v, input int change_after, input logic [31:0] junk);
    do @(negedge CLK); while (ecount == 0 || ecount % 34 != 0);
    #2;
    registerToOutput = v;
    q.push_back(ref_model(v));
    if (change_after > 0) begin
      repeat (change_after + 1) @(posedge CLK);
      #1 registerToOutput = junk;
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog at t=%0t got timeout exp finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] v;
    repeat (3) @(posedge CLK);
    do_reset(0, 32'h12345678);
    apply(32'd12345678, 0, 0);
    apply(32'hFFFF_FFFF, 0, 0);
    apply(32'hFFFF_FF85, 0, 0);
    apply(32'd99999999, 0, 0);
    apply(32'd100000000, 0, 0);
    apply(-32'sd99999999, 0, 0);
    apply(32'h8000_0000, 0, 0);
    apply(32'd0, 0, 0);
    apply(32'd42, 10, 32'd7);
    apply(32'd7, 0, 0);
    apply(32'd31415926, 0, 0);
    repeat (21) @(posedge CLK);
    do_reset(1, 32'd555);
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = -$urandom_range(0, 99999999);
        default: v = $urandom_range(0, 1) ? 32'd99999990 + $urandom_range(0, 20)
                                          : -(32'd99999990 + $urandom_range(0, 20));
      endcase
      apply(v, $urandom_range(0, 30), $urandom);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
